// File: rtl/banked_scratchpad_if.sv
// Request/response bundle for banked_scratchpad: per-port valid/ready request
// channel plus the one-cycle response channel, flattened per port.
interface banked_scratchpad_if #(
    parameter int NUM_PORTS = 5,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
);
    logic [NUM_PORTS-1:0]          req_valid;
    logic [NUM_PORTS-1:0]          req_we;
    logic [NUM_PORTS*ADDR_W-1:0]   req_addr;
    logic [NUM_PORTS*DATA_W-1:0]   req_wdata;
    logic [NUM_PORTS*DATA_W/8-1:0] req_be;
    logic [NUM_PORTS-1:0]          req_ready;
    logic [NUM_PORTS-1:0]          resp_valid;
    logic [NUM_PORTS*DATA_W-1:0]   resp_rdata;
    logic [NUM_PORTS-1:0]          resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/banked_scratchpad.sv
// Multi-port, word-interleaved banked scratch pad with per-bank round-robin
// arbitration. Define SPM_CONFLICT_CNT_EN to add per-bank conflict counters.
module banked_scratchpad #(
    parameter int NUM_PORTS  = 5,
    parameter int NUM_BANKS  = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BANK_WORDS = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    banked_scratchpad_if.slave      bus
`ifdef SPM_CONFLICT_CNT_EN
    ,
    output logic [NUM_BANKS*16-1:0] conflict_cnt
`endif
);
    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int IDX_W  = $clog2(BANK_WORDS);
    localparam int PTR_W  = $clog2(NUM_PORTS);
    localparam int HI_SH  = OFF_W + BANK_W + IDX_W;

    logic [BANK_W-1:0]    bank_sel [NUM_PORTS];
    logic [IDX_W-1:0]     idx_sel  [NUM_PORTS];
    logic [NUM_PORTS-1:0] oor;

    logic [NUM_PORTS-1:0] grant_all [NUM_BANKS];
    logic [NUM_PORTS-1:0] gnt_q     [NUM_BANKS];
    logic [DATA_W-1:0]    rdata_q   [NUM_BANKS];
    logic [NUM_BANKS-1:0] rd_q;
    logic [NUM_BANKS-1:0] err_q;

    genvar gi;

    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_dec
        logic [ADDR_W-1:0] addr;
        assign addr         = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign bank_sel[gi] = BANK_W'(addr >> OFF_W);
        assign idx_sel[gi]  = IDX_W'(addr >> (OFF_W + BANK_W));
        // Any bit above the bank index makes the access out of range.
        assign oor[gi]      = (addr >> HI_SH) != '0;
    end

    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [NUM_PORTS-1:0] bank_req;
        logic [NUM_PORTS-1:0] grant;
        logic [NUM_PORTS-1:0] gnt_reg;
        logic [PTR_W-1:0]     ptr_reg;
        logic [PTR_W-1:0]     ptr_next;
        logic [PTR_W-1:0]     gidx;
        logic                 gany;
        logic                 rd_reg;
        logic                 err_reg;
        logic                 acc_we;
        logic                 acc_oor;
        logic [IDX_W-1:0]     acc_idx;
        logic [DATA_W-1:0]    acc_wdata;
        logic [BYTES-1:0]     acc_be;
        logic [DATA_W-1:0]    rdata_reg;
        logic [DATA_W-1:0]    mem [BANK_WORDS];

        // Search starts at the pointer and wraps; nothing is granted in reset.
        always_comb begin
            int p;
            p        = 0;
            bank_req = '0;
            grant    = '0;
            gidx     = '0;
            gany     = 1'b0;
            for (int k = 0; k < NUM_PORTS; k++)
                bank_req[k] = bus.req_valid[k] && (bank_sel[k] == BANK_W'(gi));
            for (int k = 0; k < NUM_PORTS; k++) begin
                p = int'(ptr_reg) + k;
                if (p >= NUM_PORTS) p = p - NUM_PORTS;
                if (!gany && bank_req[p] && !reset) begin
                    gany = 1'b1;
                    gidx = PTR_W'(p);
                end
            end
            if (gany) grant[gidx] = 1'b1;
            ptr_next = ptr_reg;
            if (gany)
                ptr_next = (gidx == PTR_W'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;
        end

        assign acc_we    = bus.req_we[gidx];
        assign acc_oor   = oor[gidx];
        assign acc_idx   = idx_sel[gidx];
        assign acc_wdata = bus.req_wdata[gidx*DATA_W +: DATA_W];
        assign acc_be    = bus.req_be[gidx*BYTES +: BYTES];

        always_ff @(posedge clk) begin
            if (gany && !acc_oor) begin
                if (acc_we) begin
                    for (int k = 0; k < BYTES; k++)
                        if (acc_be[k]) mem[acc_idx][k*8 +: 8] <= acc_wdata[k*8 +: 8];
                end else begin
                    rdata_reg <= mem[acc_idx];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                ptr_reg <= '0;
                gnt_reg <= '0;
                rd_reg  <= 1'b0;
                err_reg <= 1'b0;
            end else begin
                ptr_reg <= ptr_next;
                gnt_reg <= grant;
                rd_reg  <= gany && !acc_we && !acc_oor;
                err_reg <= gany && acc_oor;
            end
        end

        assign grant_all[gi] = grant;
        assign gnt_q[gi]     = gnt_reg;
        assign rdata_q[gi]   = rdata_reg;
        assign rd_q[gi]      = rd_reg;
        assign err_q[gi]     = err_reg;

`ifdef SPM_CONFLICT_CNT_EN
        logic [15:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (reset)
                cnt_reg <= '0;
            else if ($countones(bank_req) > 1 && cnt_reg != 16'hFFFF)
                cnt_reg <= cnt_reg + 16'd1;
        end
        assign conflict_cnt[gi*16 +: 16] = cnt_reg;
`endif
    end

    logic [NUM_PORTS-1:0]        ready_c;
    logic [NUM_PORTS-1:0]        valid_c;
    logic [NUM_PORTS-1:0]        err_c;
    logic [NUM_PORTS*DATA_W-1:0] rdata_c;

    // Each port holds at most one grant per cycle, so OR-ing banks is a one-hot mux.
    always_comb begin
        ready_c = '0;
        valid_c = '0;
        err_c   = '0;
        rdata_c = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                ready_c[p] = ready_c[p] | grant_all[b][p];
                valid_c[p] = valid_c[p] | gnt_q[b][p];
                if (gnt_q[b][p]) begin
                    err_c[p] = err_c[p] | err_q[b];
                    if (rd_q[b])
                        rdata_c[p*DATA_W +: DATA_W] = rdata_c[p*DATA_W +: DATA_W] | rdata_q[b];
                end
            end
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.resp_valid = valid_c;
    assign bus.resp_err   = err_c;
    assign bus.resp_rdata = rdata_c;
endmodule

// File: tb/tb_banked_scratchpad.sv
// Directed bench for banked_scratchpad: reset state, read/write, byte masks,
// round-robin order, parallel banks, out-of-range and reset mid-operation.
module tb_banked_scratchpad;
    localparam int NP = 5;
    localparam int NB = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    banked_scratchpad_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();
`ifdef SPM_CONFLICT_CNT_EN
    logic [NB*16-1:0] conflict_cnt;
`endif

    banked_scratchpad #(
        .NUM_PORTS(NP), .NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .BANK_WORDS(256)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SPM_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
    endtask

    task automatic set_req(input int p, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b);
        bus.req_valid[p]         = 1'b1;
        bus.req_we[p]            = we;
        bus.req_addr[p*AW +: AW] = a;
        bus.req_wdata[p*DW +: DW] = d;
        bus.req_be[p*4 +: 4]     = b;
    endtask

    function automatic logic [63:0] rd(input int p);
        return 64'(bus.resp_rdata[p*DW +: DW]);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    int rr_cnt [NP];
    logic [4:0] rr_exp [6];

    initial begin
        rr_exp = '{5'b00001, 5'b00100, 5'b10000, 5'b00001, 5'b00100, 5'b10000};
        for (int i = 0; i < NP; i++) rr_cnt[i] = 0;

        // Reset state
        idle();
        reset = 1'b1;
        tick(); tick();
        check_vec("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_vec("rst_resp_err",   64'(bus.resp_err),   64'd0);
        check_vec("rst_rdata_zero", 64'(bus.resp_rdata == '0), 64'd1);
        check_vec("rst_ready_idle", 64'(bus.req_ready), 64'd0);
        set_req(0, 1'b1, 32'h10, 32'h0BAD0BAD, 4'hF);
        #1 check_vec("rst_ready_blocked", 64'(bus.req_ready), 64'd0);
        tick();
        check_vec("rst_no_resp", 64'(bus.resp_valid), 64'd0);
        reset = 1'b0;

        // Single write then read from another port
        idle();
        set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        #1 check_vec("wr0_ready", 64'(bus.req_ready), 64'h01);
        tick();
        check_vec("wr0_ack_valid", 64'(bus.resp_valid), 64'h01);
        check_vec("wr0_ack_rdata", rd(0), 64'd0);
        check_vec("wr0_ack_err",   64'(bus.resp_err), 64'd0);
        idle();
        set_req(3, 1'b0, 32'h10, 32'h0, 4'h0);
        #1 check_vec("rd3_ready", 64'(bus.req_ready), 64'h08);
        tick();
        check_vec("rd3_valid", 64'(bus.resp_valid), 64'h08);
        check_vec("rd3_rdata", rd(3), 64'hDEADBEEF);
        check_vec("rd3_err",   64'(bus.resp_err), 64'd0);

        // Byte mask on bank 1
        idle();
        set_req(1, 1'b1, 32'h04, 32'h00000000, 4'hF);
        tick();
        idle();
        set_req(1, 1'b1, 32'h04, 32'hAABBCCDD, 4'h5);
        tick();
        idle();
        set_req(2, 1'b0, 32'h04, 32'h0, 4'h0);
        tick();
        check_vec("bemask_rdata", rd(2), 64'h00BB00DD);

        // Parallel writes into banks 0, 2, 3
        idle();
        set_req(0, 1'b1, 32'h00, 32'h11111111, 4'hF);
        set_req(2, 1'b1, 32'h08, 32'h33333333, 4'hF);
        set_req(3, 1'b1, 32'h0C, 32'h44444444, 4'hF);
        #1 check_vec("par_wr_ready", 64'(bus.req_ready), 64'h0D);
        tick();
        check_vec("par_wr_ack", 64'(bus.resp_valid), 64'h0D);

        // Parallel reads across all four banks
        idle();
        set_req(0, 1'b0, 32'h00, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h04, 32'h0, 4'h0);
        set_req(2, 1'b0, 32'h08, 32'h0, 4'h0);
        set_req(3, 1'b0, 32'h0C, 32'h0, 4'h0);
        #1 check_vec("par_rd_ready", 64'(bus.req_ready), 64'h0F);
        tick();
        check_vec("par_rd_valid", 64'(bus.resp_valid), 64'h0F);
        check_vec("par_rd_p0", rd(0), 64'h11111111);
        check_vec("par_rd_p1", rd(1), 64'h00BB00DD);
        check_vec("par_rd_p2", rd(2), 64'h33333333);
        check_vec("par_rd_p3", rd(3), 64'h44444444);

        // Round robin on bank 2 from a fresh pointer
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 1'b0, 32'h08, 32'h0, 4'h0);
        set_req(2, 1'b0, 32'h18, 32'h0, 4'h0);
        set_req(4, 1'b0, 32'h28, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            #1 check_vec($sformatf("rr_ready_c%0d", i), 64'(bus.req_ready), 64'(rr_exp[i]));
            for (int p = 0; p < NP; p++) if (bus.req_ready[p]) rr_cnt[p]++;
            tick();
        end
        idle();
        check_vec("rr_cnt_p0", 64'(rr_cnt[0]), 64'd2);
        check_vec("rr_cnt_p2", 64'(rr_cnt[2]), 64'd2);
        check_vec("rr_cnt_p4", 64'(rr_cnt[4]), 64'd2);
`ifdef SPM_CONFLICT_CNT_EN
        check_vec("conflict_bank2", 64'(conflict_cnt[2*16 +: 16]), 64'd6);
        check_vec("conflict_bank0", 64'(conflict_cnt[0 +: 16]), 64'd0);
`endif
        tick();

        // Out-of-range write must be acknowledged with an error and not land
        idle();
        set_req(1, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        #1 check_vec("oor_ready", 64'(bus.req_ready), 64'h02);
        tick();
        check_vec("oor_valid", 64'(bus.resp_valid), 64'h02);
        check_vec("oor_err",   64'(bus.resp_err),   64'h02);
        check_vec("oor_rdata", rd(1), 64'd0);
        idle();
        set_req(0, 1'b0, 32'h00, 32'h0, 4'h0);
        tick();
        check_vec("oor_word0_kept", rd(0), 64'h11111111);
        check_vec("oor_word0_err",  64'(bus.resp_err), 64'd0);

        // Reset mid-operation suppresses the write and its response
        idle();
        set_req(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        tick();
        idle();
        reset = 1'b1;
        set_req(0, 1'b1, 32'h20, 32'h12345678, 4'hF);
        #1 check_vec("midrst_ready", 64'(bus.req_ready), 64'd0);
        tick();
        reset = 1'b0;
        idle();
        check_vec("midrst_no_resp", 64'(bus.resp_valid), 64'd0);
`ifdef SPM_CONFLICT_CNT_EN
        check_vec("midrst_conflict_clr", 64'(conflict_cnt == '0), 64'd1);
`endif
        tick();
        check_vec("midrst_no_resp2", 64'(bus.resp_valid), 64'd0);
        set_req(0, 1'b0, 32'h20, 32'h0, 4'h0);
        tick();
        idle();
        check_vec("midrst_rd_valid", 64'(bus.resp_valid), 64'h01);
        check_vec("midrst_rd_rdata", rd(0), 64'hCAFEF00D);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/banked_scratchpad.md
Name: banked_scratchpad

Overview:
Parametrised multi-port, multi-bank scratch pad memory. It generalises the fixed five-port, four-bank scratch pad to NUM_PORTS requesters and NUM_BANKS word-interleaved banks. Each bank has a per-bank round-robin arbiter, each port has a valid/ready handshake, and a one-cycle registered response path routes each bank's read data back to the port that was granted. It sits between core/DMA request sources and on-chip SRAM.

Parameters:
NUM_PORTS, 5, number of requesting ports (2..8)
NUM_BANKS, 4, number of banks; power of two (2..16)
DATA_W, 32, word width in bits; multiple of 8
ADDR_W, 32, byte address width
BANK_WORDS, 256, words per bank; power of two

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_PORTS  per-port request valid
req_we  in  NUM_PORTS  per-port write enable (1 = write, 0 = read)
req_addr  in  NUM_PORTS*ADDR_W  per-port byte address; port p occupies slice [p*ADDR_W +: ADDR_W]
req_wdata  in  NUM_PORTS*DATA_W  per-port write data
req_be  in  NUM_PORTS*DATA_W/8  per-port byte enables for writes
req_ready  out  NUM_PORTS  per-port request accepted this cycle
resp_valid  out  NUM_PORTS  per-port response valid; one cycle after acceptance
resp_rdata  out  NUM_PORTS*DATA_W  per-port read data
resp_err  out  NUM_PORTS  per-port out-of-range error flag

Behaviour:
- Address decode: word offset = addr[log2(DATA_W/8)-1:0] (ignored). Bank = next log2(NUM_BANKS) bits. Index = next log2(BANK_WORDS) bits. Any set bit above the index is out of range.
- Arbitration is per bank, combinational from req_valid and bank decode. Each bank keeps a round-robin pointer ptr_b, reset to 0.
  - Grant goes to the first requesting port at index >= ptr_b, wrapping modulo NUM_PORTS.
  - On a grant to port g, ptr_b <= (g+1) mod NUM_PORTS. With no grant, ptr_b holds.
- req_ready[p] = 1 only when port p is granted by its target bank. A transfer occurs on req_valid & req_ready. At most one access per bank per cycle; different banks serve different ports concurrently.
- req_ready is not registered. A requester may drop valid without a transfer, and its payload may change while not ready.
- Write, in range: bytes with req_be set are written at the clock edge. Bytes with be = 0 are unchanged.
- Read, in range: resp_rdata holds the bank word on the cycle after acceptance (latency 1), with resp_valid = 1.
- Writes also produce resp_valid = 1 one cycle later, with resp_rdata = 0 (write acknowledge).
- Out of range: the request is still arbitrated and accepted. The write is suppressed and no array read occurs. Next cycle: resp_valid = 1, resp_err = 1, resp_rdata = 0.
- There is no response back-pressure; a port must sink a response on the cycle it is presented.
- Response routing: a registered grant vector per bank (grant_q) selects which bank's output drives each port. Because at most one grant per port per cycle, routing is one-hot.
- Reset values: resp_valid = 0, resp_err = 0, resp_rdata = 0, every grant_q = 0, every ptr_b = 0. req_ready is 0 whenever req_valid = 0.
- Array contents are not reset.
- Reset asserted mid-operation: requests accepted in the reset cycle produce no response, and writes in the reset cycle are suppressed. The first legal acceptance is the cycle after reset deasserts.
- Simultaneous events: the same port cannot hit two banks in one cycle (single address per port). Two ports writing the same word cannot both win, because the bank serialises them in round-robin order.

Optional Feature:
SPM_CONFLICT_CNT_EN: when defined, adds output conflict_cnt (NUM_BANKS*16).
- Per-bank 16-bit counter that increments each cycle that bank has two or more requesters.
- The counter saturates at 0xFFFF and clears on reset.
When undefined, the port and all counter logic are absent, and the behaviour is otherwise identical.

Test Plan:
- Single read: after reset, write 0xDEADBEEF with be = 0xF via port 0 to address 0x10 (bank 0, index 1); then read the same address from port 3 -> resp_valid[3] = 1 one cycle after acceptance, resp_rdata = 0xDEADBEEF, resp_err = 0.
- Byte mask: write 0xAABBCCDD with be = 0x5 to address 0x04 (bank 1), which previously held 0 -> read returns 0x00BB00DD.
- Round-robin: ports 0, 2 and 4 hold read requests to bank 2 continuously for 6 cycles -> grant order 0, 2, 4, 0, 2, 4; each port's req_ready is high on exactly 2 cycles.
- Parallel banks: ports 0 to 3 read addresses 0x0, 0x4, 0x8 and 0xC in the same cycle -> all four req_ready = 1 together; next cycle four resp_valid, each carrying its own bank data.
- Out of range: port 1 writes to 0x1000 (index overflow with defaults) -> req_ready = 1; next cycle resp_err[1] = 1, resp_rdata = 0; a read of 0x0 shows its word unchanged.
- Reset mid-operation: assert reset for 1 cycle while port 0 writes 0x12345678 to 0x20 -> no resp_valid appears; a subsequent read of 0x20 returns the value held before the reset. With SPM_CONFLICT_CNT_EN defined, conflict_cnt = 0 after reset.
